i2c_rx_byte_buffer: RTL

Receive-side counterpart to the master's transmit byte array. It collects serial bits sampled by the I2C master during a read transfer and assembles them MSB-first into up to 8 bytes. It exposes the bytes as a parallel 64-bit bus and tells the bit engine whether to ACK or NACK each received byte. It sits between the master's SDA sampling logic and the host-side register file.

---
 rtl/i2c_rx_byte_buffer.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/i2c_rx_byte_buffer.sv
// ---------------------------------------------------------------------------
// i2c_rx_byte_buffer
//
// Receive-side byte assembler for the I2C master. Serial bits sampled from
// SDA during a read transfer are shifted in MSB-first and packed into up to
// MAX_BYTES byte slots. The slots are presented as one parallel bus for the
// host register file. With every completed byte the block tells the bit
// engine whether to ACK (more bytes wanted) or NACK (final byte).
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   rst        synchronous active-high reset, highest priority
//   start      one-cycle pulse: clear buffered state and begin a reception
//   length     bytes to receive, sampled on start, clamped to MAX_BYTES
//   bit_valid  one-cycle strobe qualifying bit_in
//   bit_in     sampled SDA data bit
//   data_out   byte k at [8*MAX_BYTES-1-8k -: 8], byte 0 in the MSBs
//   count      number of completed bytes
//   byte_done  one-cycle pulse when a byte has been written to its slot
//   ack_bit    meaningful with byte_done: 0 = ACK, 1 = NACK (final byte)
//   busy       reception in progress
//   done       reception complete, held until start or rst
//   overflow   sticky: a bit arrived after completion, cleared by start/rst
// ---------------------------------------------------------------------------
module i2c_rx_byte_buffer #(
  parameter int MAX_BYTES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [3:0]             length,
  input  logic                   bit_valid,
  input  logic                   bit_in,
  output logic [8*MAX_BYTES-1:0] data_out,
  output logic [3:0]             count,
  output logic                   byte_done,
  output logic                   ack_bit,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] eff_len;    // length captured on start, already clamped
  logic [6:0] shift_p0;   // the first seven bits of the byte in progress
  logic [2:0] bit_cnt;    // bits of the current byte received so far

  // Requests longer than the slot array are truncated to a full buffer.
  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    if (len > 4'(MAX_BYTES)) begin
      return 4'(MAX_BYTES);
    end
    return len;
  endfunction

  // Completed byte: seven buffered bits followed by the current one, so the
  // first bit on the wire lands in bit 7.
  function automatic logic [7:0] assemble_byte(input logic [6:0] head,
                                               input logic       tail);
    return {head, tail};
  endfunction

  logic [3:0] count_nxt;
  logic [7:0] byte_nxt;
  logic       last_byte;

  always_comb begin
    count_nxt = count + 4'd1;
    byte_nxt  = assemble_byte(shift_p0, bit_in);
    last_byte = (count_nxt == eff_len);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      eff_len   <= '0;
      shift_p0  <= '0;
      bit_cnt   <= '0;
      data_out  <= '0;
      count     <= '0;
      byte_done <= 1'b0;
      ack_bit   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      byte_done <= 1'b0;

      if (start) begin
        // Restart from any state; a bit strobed in the same cycle is dropped.
        eff_len  <= clamp_len(length);
        shift_p0 <= '0;
        bit_cnt  <= '0;
        data_out <= '0;
        count    <= '0;
        overflow <= 1'b0;
        if (clamp_len(length) == 4'd0) begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          state <= ST_COLLECT;
          busy  <= 1'b1;
          done  <= 1'b0;
        end
      end else begin
        unique case (state)
          ST_IDLE: begin
            // Stray bits before a start are ignored.
          end

          ST_COLLECT: begin
            if (bit_valid) begin
              shift_p0 <= byte_nxt[6:0];
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                // Slot index is the pre-increment count; constant slice
                // bases keep the write a plain per-slot enable.
                for (int k = 0; k < MAX_BYTES; k++) begin
                  if (count == 4'(k)) begin
                    data_out[8*(MAX_BYTES-1-k) +: 8] <= byte_nxt;
                  end
                end
                count     <= count_nxt;
                byte_done <= 1'b1;
                ack_bit   <= last_byte;
                if (last_byte) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end
              end
            end
          end

          ST_DONE: begin
            if (bit_valid) begin
              overflow <= 1'b1;
            end
          end

          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
